// File: rtl/dmac_bus_arbiter.sv
// dmac_bus_arbiter
//   Two-master / two-slave shared bus in front of the DMA controller.
//   M0 (host) and M1 (DMAC master port) compete for the bus through a
//   non-preemptive arbiter that parks on M0. The granted master's address
//   is decoded on address[7:5] to S0 (DMAC registers) or S1 (data memory).
//   Slave read data comes back one cycle later through a registered
//   read-select and is broadcast to both masters on M_din.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   M0_req/M0_wr/M0_address/M0_dout   master 0 request, direction, address, write data
//   M0_grant                          master 0 owns the bus
//   M1_req/M1_wr/M1_address/M1_dout   master 1 request, direction, address, write data
//   M1_grant                          master 1 owns the bus
//   M_din                             read data returned to both masters
//   S0_sel, S1_sel                    slave selects
//   S_wr, S_address, S_din            write strobe, address, write data to slaves
//   S0_dout, S1_dout                  slave read data (valid the cycle after select)
//
// state    | meaning
// ---------+----------------------------------------------
// GRANT_M0 | M0 owns the bus (also the idle/park state)
// GRANT_M1 | M1 owns the bus until it drops M1_req

module dmac_bus_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter logic [2:0]  S0_PREFIX = 3'b000,
  parameter logic [2:0]  S1_PREFIX = 3'b001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  output logic              M0_grant,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M1_grant,
  output logic [DATA_W-1:0] M_din,
  output logic              S0_sel,
  output logic              S1_sel,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_din,
  input  logic [DATA_W-1:0] S0_dout,
  input  logic [DATA_W-1:0] S1_dout
);

  typedef enum logic {GRANT_M0, GRANT_M1} state_t;
  typedef enum logic [1:0] {RSEL_NONE, RSEL_S0, RSEL_S1} rsel_t;

  state_t state_q, state_d;
  rsel_t  rsel_q, rsel_d;
  logic   req_g;
  logic   wr_g;
  logic [2:0] prefix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GRANT_M0;
      rsel_q  <= RSEL_NONE;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
    end
  end

  // Non-preemptive: the owner keeps the bus while its req stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT_M0: if (!M0_req && M1_req) state_d = GRANT_M1;
      GRANT_M1: if (!M1_req)           state_d = GRANT_M0;
      default:                         state_d = GRANT_M0;
    endcase
  end

  assign M0_grant = (state_q == GRANT_M0);
  assign M1_grant = (state_q == GRANT_M1);

  always_comb begin
    S_address = M0_address;
    S_din     = M0_dout;
    wr_g      = M0_wr;
    req_g     = M0_req;
    if (state_q == GRANT_M1) begin
      S_address = M1_address;
      S_din     = M1_dout;
      wr_g      = M1_wr;
      req_g     = M1_req;
    end
    // Disqualify the request while reset is asserted so no partial
    // select or write strobe leaks out during an async reset.
    req_g = req_g & reset_n;
  end

  assign prefix = S_address[ADDR_W-1 -: 3];
  assign S0_sel = req_g && (prefix == S0_PREFIX);
  assign S1_sel = req_g && (prefix == S1_PREFIX);
  assign S_wr   = req_g && wr_g;

  // Remember which slave a read targeted so its registered output can be
  // steered back next cycle; writes and unmapped reads return zero.
  always_comb begin
    rsel_d = RSEL_NONE;
    if (S0_sel && !S_wr)      rsel_d = RSEL_S0;
    else if (S1_sel && !S_wr) rsel_d = RSEL_S1;
  end

  always_comb begin
    M_din = '0;
    case (rsel_q)
      RSEL_S0: M_din = S0_dout;
      RSEL_S1: M_din = S1_dout;
      default: M_din = '0;
    endcase
  end

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
module tb_dmac_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant;
  logic [31:0] m_din;
  logic        s0_sel, s1_sel, s_wr;
  logic [7:0]  s_address;
  logic [31:0] s_din;
  logic [31:0] s0_dout, s1_dout;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmac_bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .M0_req     (m0_req),
    .M0_wr      (m0_wr),
    .M0_address (m0_address),
    .M0_dout    (m0_dout),
    .M0_grant   (m0_grant),
    .M1_req     (m1_req),
    .M1_wr      (m1_wr),
    .M1_address (m1_address),
    .M1_dout    (m1_dout),
    .M1_grant   (m1_grant),
    .M_din      (m_din),
    .S0_sel     (s0_sel),
    .S1_sel     (s1_sel),
    .S_wr       (s_wr),
    .S_address  (s_address),
    .S_din      (s_din),
    .S0_dout    (s0_dout),
    .S1_dout    (s1_dout)
  );

  // Slave models: registered read data, preloaded with recognisable patterns.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= 32'hA000_0000 + 32'(i);
        mem1[i] <= 32'hB000_0000 + 32'(i);
      end
      s0_dout <= '0;
      s1_dout <= '0;
    end else begin
      if (s0_sel && s_wr) mem0[s_address[4:0]] <= s_din;
      if (s1_sel && s_wr) mem1[s_address[4:0]] <= s_din;
      s0_dout <= mem0[s_address[4:0]];
      s1_dout <= mem1[s_address[4:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_address = '0; m0_dout = '0;
    m1_req = 0; m1_wr = 0; m1_address = '0; m1_dout = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant: got m0=%b m1=%b expected m0=1 m1=0", m0_grant, m1_grant);
    end
    checks++;
    if (s0_sel !== 1'b0 || s1_sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel: got s0=%b s1=%b expected 0 0", s0_sel, s1_sel);
    end
    checks++;
    if (m_din !== 32'h0) begin
      failures++;
      $display("FAIL reset_mdin: got %h expected 00000000", m_din);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_m0_write_read();
    m0_req = 1; m0_wr = 1; m0_address = 8'h24; m0_dout = 32'h0000_0005;
    @(negedge clk);
    checks++;
    if (s1_sel !== 1'b1 || s0_sel !== 1'b0 || s_wr !== 1'b1) begin
      failures++;
      $display("FAIL m0_write_strobe: got s0=%b s1=%b wr=%b expected 0 1 1", s0_sel, s1_sel, s_wr);
    end
    checks++;
    if (s_din !== 32'h5 || s_address !== 8'h24) begin
      failures++;
      $display("FAIL m0_write_data: got addr=%h din=%h expected 24 00000005", s_address, s_din);
    end
    step();
    checks++;
    if (m_din !== 32'h0) begin
      failures++;
      $display("FAIL write_no_readback: got %h expected 00000000", m_din);
    end
    m0_wr = 0;
    exp_q.push_back(32'h0000_0005);
    @(negedge clk);
    checks++;
    if (s1_sel !== 1'b1 || s_wr !== 1'b0) begin
      failures++;
      $display("FAIL m0_read_sel: got s1=%b wr=%b expected 1 0", s1_sel, s_wr);
    end
    step();
    m0_req = 0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL m0_read_data: scoreboard empty");
    end else begin
      exp_v = exp_q.pop_front();
      if (m_din !== exp_v) begin
        failures++;
        $display("FAIL m0_read_data: got %h expected %h", m_din, exp_v);
      end
    end
    step();
  endtask

  task automatic test_m1_handover();
    m0_req = 0; m1_req = 1; m1_wr = 0; m1_address = 8'h08;
    @(negedge clk);
    checks++;
    if (m0_grant !== 1'b1 || s0_sel !== 1'b0) begin
      failures++;
      $display("FAIL m1_pre_grant: got m0_grant=%b s0=%b expected 1 0", m0_grant, s0_sel);
    end
    step();
    exp_q.push_back(32'hA000_0008);
    @(negedge clk);
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0 || s0_sel !== 1'b1) begin
      failures++;
      $display("FAIL m1_grant: got m1=%b m0=%b s0=%b expected 1 0 1", m1_grant, m0_grant, s0_sel);
    end
    step();
    m1_req = 0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL m1_read_data: scoreboard empty");
    end else begin
      exp_v = exp_q.pop_front();
      if (m_din !== exp_v) begin
        failures++;
        $display("FAIL m1_read_data: got %h expected %h", m_din, exp_v);
      end
    end
    @(negedge clk);
    checks++;
    if (m1_grant !== 1'b1 || s0_sel !== 1'b0) begin
      failures++;
      $display("FAIL m1_release_hold: got m1=%b s0=%b expected 1 0", m1_grant, s0_sel);
    end
    step();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++;
      $display("FAIL m1_release: got m0=%b m1=%b expected 1 0", m0_grant, m1_grant);
    end
  endtask

  task automatic test_simultaneous();
    m0_req = 1; m0_wr = 0; m0_address = 8'h30;
    m1_req = 1; m1_wr = 0; m1_address = 8'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m0_grant !== 1'b1 || s_address !== 8'h30) begin
        failures++;
        $display("FAIL simul_m0_keeps[%0d]: got m0=%b addr=%h expected 1 30", c, m0_grant, s_address);
      end
      step();
    end
    m0_req = 0;
    @(negedge clk);
    checks++;
    if (m0_grant !== 1'b1 || s1_sel !== 1'b0 || s0_sel !== 1'b0) begin
      failures++;
      $display("FAIL simul_drop: got m0=%b s0=%b s1=%b expected 1 0 0", m0_grant, s0_sel, s1_sel);
    end
    step();
    @(negedge clk);
    checks++;
    if (m1_grant !== 1'b1 || s_address !== 8'h10 || s0_sel !== 1'b1) begin
      failures++;
      $display("FAIL simul_handover: got m1=%b addr=%h s0=%b expected 1 10 1", m1_grant, s_address, s0_sel);
    end
    step();
    m1_req = 0;
    step();
    step();
  endtask

  task automatic test_ungranted();
    m0_req = 1; m0_wr = 0; m0_address = 8'h24;
    m1_req = 1; m1_wr = 1; m1_address = 8'h00; m1_dout = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (s0_sel !== 1'b0 || s_wr !== 1'b0 || m1_grant !== 1'b0) begin
      failures++;
      $display("FAIL ungranted_write: got s0=%b wr=%b m1=%b expected 0 0 0", s0_sel, s_wr, m1_grant);
    end
    step();
    m0_req = 0; m1_req = 0; m1_wr = 0;
    step();
    m0_req = 1; m0_wr = 0; m0_address = 8'h00;
    exp_q.push_back(32'hA000_0000);
    step();
    m0_req = 0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL ungranted_mem: scoreboard empty");
    end else begin
      exp_v = exp_q.pop_front();
      if (m_din !== exp_v) begin
        failures++;
        $display("FAIL ungranted_mem: got %h expected %h", m_din, exp_v);
      end
    end
    step();
  endtask

  task automatic test_unmapped();
    m0_req = 1; m0_wr = 0; m0_address = 8'h80;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (s0_sel !== 1'b0 || s1_sel !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_sel: got s0=%b s1=%b expected 0 0", s0_sel, s1_sel);
    end
    step();
    m0_req = 0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unmapped_data: scoreboard empty");
    end else begin
      exp_v = exp_q.pop_front();
      if (m_din !== exp_v) begin
        failures++;
        $display("FAIL unmapped_data: got %h expected %h", m_din, exp_v);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [4];
    logic [31:0] datas [4];
    addrs = '{8'h24, 8'h05, 8'h3F, 8'h00};
    datas = '{32'h0000_0005, 32'hA000_0005, 32'hB000_001F, 32'hA000_0000};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_read[%0d]: scoreboard empty", i - 1);
        end else begin
          exp_v = exp_q.pop_front();
          if (m_din !== exp_v) begin
            failures++;
            $display("FAIL b2b_read[%0d]: got %h expected %h", i - 1, m_din, exp_v);
          end
        end
      end
      if (i < 4) begin
        m0_req = 1; m0_wr = 0; m0_address = addrs[i];
        exp_q.push_back(datas[i]);
      end else begin
        m0_req = 0;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    m0_req = 0; m1_req = 1; m1_wr = 0; m1_address = 8'h24;
    step();
    step();
    checks++;
    if (m1_grant !== 1'b1 || m_din !== 32'h5) begin
      failures++;
      $display("FAIL burst_before_reset: got m1=%b mdin=%h expected 1 00000005", m1_grant, m_din);
    end
    m1_wr = 1; m1_dout = 32'h1234_5678;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_grant: got m0=%b m1=%b expected 1 0", m0_grant, m1_grant);
    end
    checks++;
    if (m_din !== 32'h0 || s_wr !== 1'b0 || s1_sel !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_path: got mdin=%h wr=%b s1=%b expected 00000000 0 0", m_din, s_wr, s1_sel);
    end
    m1_req = 0; m1_wr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (m0_grant !== 1'b1 || m_din !== 32'h0) begin
      failures++;
      $display("FAIL post_reset: got m0=%b mdin=%h expected 1 00000000", m0_grant, m_din);
    end
  endtask

  initial begin
    test_reset();
    test_m0_write_read();
    test_m1_handover();
    test_simultaneous();
    test_ungranted();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmac_bus_arbiter.md
Name: dmac_bus_arbiter

Overview:
Two-master, two-slave shared bus that sits directly in front of the DMA controller. It arbitrates between the host/testbench master (M0) and the DMA controller master port (M1), which drives M1_req and receives M1_grant. It decodes the granted master's address to the DMA controller's register slave (S0) or the data memory (S1). It returns slave read data to both masters through a registered read-select.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 32, bus data width
S0_PREFIX, 3'b000, address[7:5] value selecting S0 (DMAC registers, 0x00-0x1F)
S1_PREFIX, 3'b001, address[7:5] value selecting S1 (memory, 0x20-0x3F)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
M0_req  in  1  master 0 bus request
M0_wr  in  1  master 0 write (1) / read (0)
M0_address  in  8  master 0 address
M0_dout  in  32  master 0 write data
M0_grant  out  1  master 0 owns bus
M1_req  in  1  master 1 (DMAC) bus request
M1_wr  in  1  master 1 write/read
M1_address  in  8  master 1 address
M1_dout  in  32  master 1 write data
M1_grant  out  1  master 1 owns bus
M_din  out  32  read data returned to both masters
S0_sel  out  1  slave 0 select
S1_sel  out  1  slave 1 select
S_wr  out  1  write strobe to slaves
S_address  out  8  address to slaves
S_din  out  32  write data to slaves
S0_dout  in  32  slave 0 read data (valid cycle after select)
S1_dout  in  32  slave 1 read data (valid cycle after select)

Behaviour:
- Reset (async, reset_n=0): state=GRANT_M0, M0_grant=1, M1_grant=0, rsel_q=NONE, M_din=0. All slave selects are 0 because no request is qualified.
- FSM (registered, updates on the rising edge of clk):
  - GRANT_M0: if M0_req=1, stay. Else if M1_req=1, go to GRANT_M1. Else stay (bus parks on M0).
  - GRANT_M1: if M1_req=1, stay. Else go to GRANT_M0.
- Grants are non-preemptive. Once granted, a master keeps the bus until it drops its req.
- Grant outputs decode the current state directly. Exactly one grant is high at any time.
- Handover latency: M1_grant rises 1 cycle after M0_req falls while M1_req is high. M0 regains the bus 1 cycle after M1_req falls.
- Simultaneous M0_req and M1_req rising in GRANT_M0: M0 keeps the bus. M1 waits until M0_req drops.
- Address/data mux (combinational from the granted master): S_address, S_wr and S_din come from the granted master.
- Request qualification: req_g is the granted master's req.
  - S0_sel = req_g and (S_address[7:5]==S0_PREFIX).
  - S1_sel = req_g and (S_address[7:5]==S1_PREFIX).
  - Any other prefix selects no slave: writes are dropped and reads return 0.
- A master that requests without a grant produces no select and no write.
- S_wr is forced to 0 when req_g=0.
- Read path:
  - rsel_q (2 bits: NONE/S0/S1) is registered each cycle. It captures S0 or S1 when the corresponding select is high and S_wr=0, otherwise NONE.
  - M_din = S0_dout if rsel_q==S0, S1_dout if rsel_q==S1, else 0.
  - Read latency is therefore 1 cycle from address phase to M_din, matching the registered slave outputs.
- Back-to-back reads to different slaves return data in order, one per cycle.
- Reset mid-transfer: grant returns to M0 immediately. rsel_q clears, so M_din=0 on the next read phase. No partial write is issued after reset asserts.
- Widths are fixed at 8-bit addresses and 32-bit data. No data arithmetic is performed.

Test Plan:
- Reset: hold reset_n=0 -> M0_grant=1, M1_grant=0, S0_sel=S1_sel=0, M_din=0.
- M0 write 0x0000_0005 to 0x24, then read 0x24 -> S1_sel=1 with S_wr=1 and S_din=5. On the read, M_din=S1_dout one cycle after the read address phase.
- M0_req=0, M1_req=1 -> M1_grant=1 on the next edge. The M1 read of 0x08 gives S0_sel=1. Setting M1_req=0 returns M0_grant=1 one cycle later.
- Both requests held high from GRANT_M0 -> M0 keeps the bus. Once M0_req drops, M1_grant=1 on the next cycle while M1_req is still high.
- Ungranted M1 drives M1_wr=1 to 0x00 while M0 owns the bus -> S0_sel stays 0 and no write occurs.
- Read of 0x80 (unmapped) -> no select asserted and M_din=0. A reset_n pulse during an M1 burst -> M0_grant=1 asynchronously and rsel_q=NONE.
